// File: rtl/led_frame_buffer.sv
// Double-buffered per-LED RGB brightness store feeding the PWM stage.
// Commits swap banks only on a PWM frame boundary; reads apply the physical sink mapping.
module led_frame_buffer #(
  parameter int NUM_LEDS = 11,
  parameter int VALUE_W  = 8,
  parameter logic [6*NUM_LEDS-1:0] CHAN_MAP = {
    6'h06, 6'h24, 6'h06, 6'h24, 6'h06, 6'h24,
    6'h24, 6'h12, 6'h12, 6'h06, 6'h06
  }
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [3:0]                    wr_led,
  input  logic [1:0]                    wr_color,
  input  logic [VALUE_W-1:0]            wr_value,
  output logic                          wr_err,
  input  logic                          commit,
  output logic                          commit_pending,
  input  logic                          frame_start,
  output logic                          swap_done,
  input  logic [1:0]                    rd_sink,
  output logic [NUM_LEDS*VALUE_W-1:0]   rd_values
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t                          state_r;
  state_t                          state_next_s;
  logic                            wr_ready_s;
  logic                            commit_pending_s;
  logic                            swap_s;
  logic                            wr_hs_s;
  logic                            wr_ok_s;
  logic                            front_sel_r;
  logic                            back_sel_s;
  logic                            swap_done_r;
  logic                            wr_err_r;
  logic [VALUE_W-1:0]              bank_r [2][NUM_LEDS][3];
  logic [NUM_LEDS*VALUE_W-1:0]     rd_next_s;
  logic [NUM_LEDS*VALUE_W-1:0]     rd_values_r;

  // Logical colour wired to a physical sink; field is {s0,s1,s2}, 3 means dark.
  function automatic logic [1:0] sink_color(input logic [5:0] field, input logic [1:0] sink);
    case (sink)
      2'd0:    return field[5:4];
      2'd1:    return field[3:2];
      2'd2:    return field[1:0];
      default: return 2'd3;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a commit arms the swap, the following frame_start fires it
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (commit) state_next_s = ST_PENDING;
        else        state_next_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (frame_start) state_next_s = ST_IDLE;
        else             state_next_s = ST_PENDING;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    wr_ready_s       = 1'b1;
    commit_pending_s = 1'b0;
    swap_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        wr_ready_s       = 1'b1;
        commit_pending_s = 1'b0;
        swap_s           = 1'b0;
      end
      ST_PENDING: begin
        wr_ready_s       = 1'b0;
        commit_pending_s = 1'b1;
        swap_s           = frame_start;
      end
      default: begin
        wr_ready_s       = 1'b1;
        commit_pending_s = 1'b0;
        swap_s           = 1'b0;
      end
    endcase
  end

  assign wr_hs_s    = wr_valid & wr_ready_s;
  assign wr_ok_s    = ({1'b0, wr_led} < 5'(NUM_LEDS)) && (wr_color != 2'd3);
  assign back_sel_s = ~front_sel_r;

  // Bank select, swap and error pulses
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      front_sel_r <= 1'b0;
      swap_done_r <= 1'b0;
      wr_err_r    <= 1'b0;
    end else begin
      front_sel_r <= swap_s ? ~front_sel_r : front_sel_r;
      swap_done_r <= swap_s;
      wr_err_r    <= wr_hs_s & ~wr_ok_s;
    end
  end

  // Back-bank storage; the front bank is never written
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < NUM_LEDS; l++) begin
          for (int c = 0; c < 3; c++) begin
            bank_r[b][l][c] <= '0;
          end
        end
      end
    end else if (wr_hs_s && wr_ok_s) begin
      bank_r[back_sel_s][wr_led][wr_color] <= wr_value;
    end else begin
      bank_r <= bank_r;
    end
  end

  // Per-LED sink-to-colour mux on the pre-swap front bank
  always_comb begin : rd_mux
    logic [1:0] col_s;
    col_s     = 2'd3;
    rd_next_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      col_s = sink_color(CHAN_MAP[6*(NUM_LEDS-1-i) +: 6], rd_sink);
      if (col_s != 2'd3) begin
        rd_next_s[VALUE_W*i +: VALUE_W] = bank_r[front_sel_r][i][col_s];
      end else begin
        rd_next_s[VALUE_W*i +: VALUE_W] = '0;
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_values_r <= '0;
    end else begin
      rd_values_r <= rd_next_s;
    end
  end

  assign wr_ready       = wr_ready_s;
  assign commit_pending = commit_pending_s;
  assign swap_done      = swap_done_r;
  assign wr_err         = wr_err_r;
  assign rd_values      = rd_values_r;

endmodule
